// File: rtl/contrast_apply.sv
// Contrast datapath: out = clamp(MID + (pixel - MID) * coef), where coef is a
// shift/add code. Three-stage pipeline with one global stall enable.
module contrast_apply #(
   parameter int PIX_W = 8,
   parameter int MID   = 128,
   parameter int FRAC  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cp_update,
   input  logic [8:0]       cp_param,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             in_sof,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_sof,
   output logic             param_err
);

   localparam int         DW      = 16;
   localparam int         SW      = DW + 2;
   localparam logic [8:0] COEF_X1 = 9'b0_0000_0100;

   function automatic logic f_legal(input logic [3:0] code);
      case (code)
         4'b0000, 4'b0100, 4'b0101, 4'b0110,
         4'b0111, 4'b1001, 4'b1010: f_legal = 1'b1;
         default:                   f_legal = 1'b0;
      endcase
   endfunction

   // d carries FRAC fractional bits, so the right shifts below are exact
   function automatic logic signed [DW-1:0] f_term(input logic [3:0] code,
                                                   input logic signed [DW-1:0] d);
      case (code)
         4'b0100: f_term = d;
         4'b0101: f_term = d >>> 1;
         4'b0110: f_term = d >>> 2;
         4'b0111: f_term = d >>> 3;
         4'b1001: f_term = d <<< 1;
         4'b1010: f_term = d <<< 2;
         default: f_term = '0;
      endcase
   endfunction

   logic [8:0]              r_pending;
   logic [8:0]              r_active;
   logic                    r_param_err;

   logic                    r_s1_vld;
   logic                    r_s1_sof;
   logic signed [DW-1:0]    r_s1_d;
   logic [8:0]              r_s1_coef;

   logic                    r_s2_vld;
   logic                    r_s2_sof;
   logic signed [DW-1:0]    r_s2_acc;

   logic                    r_out_vld;
   logic                    r_out_sof;
   logic [PIX_W-1:0]        r_out_pixel;

   logic                    w_en;
   logic                    w_accept;
   logic                    w_upd_legal;
   logic [8:0]              w_upd_param;
   logic [8:0]              w_coef;
   logic signed [DW-1:0]    w_diff;
   logic signed [DW-1:0]    w_d;
   logic signed [DW-1:0]    w_t0;
   logic signed [DW-1:0]    w_t1;
   logic signed [DW-1:0]    w_acc;
   logic signed [SW-1:0]    w_sum;
   logic signed [SW-1:0]    w_rnd;
   logic signed [SW-1:0]    w_val;
   logic [PIX_W-1:0]        w_pix;

   assign w_en     = ~r_out_vld | out_ready;
   assign w_accept = in_valid & w_en;

   assign w_upd_legal = f_legal(cp_param[3:0]) & f_legal(cp_param[7:4]);
   assign w_upd_param = w_upd_legal ? cp_param : COEF_X1;

   // An SOF pixel takes the freshest parameter, including one arriving this cycle
   assign w_coef = (w_accept & in_sof) ? (cp_update ? w_upd_param : r_pending)
                                       : r_active;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending   <= COEF_X1;
         r_active    <= COEF_X1;
         r_param_err <= 1'b0;
      end else begin
         if (cp_update) begin
            r_pending   <= w_upd_param;
            r_param_err <= ~w_upd_legal;
         end
         if (w_accept & in_sof)
            r_active <= w_coef;
      end
   end

   assign w_diff = $signed({{(DW-PIX_W){1'b0}}, in_pixel}) - $signed(DW'(MID));
   assign w_d    = w_diff <<< FRAC;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_vld  <= 1'b0;
         r_s1_sof  <= 1'b0;
         r_s1_d    <= '0;
         r_s1_coef <= COEF_X1;
      end else if (w_en) begin
         r_s1_vld  <= in_valid;
         r_s1_sof  <= in_sof;
         r_s1_d    <= w_d;
         r_s1_coef <= w_coef;
      end
   end

   assign w_t0  = f_term(r_s1_coef[3:0], r_s1_d);
   assign w_t1  = f_term(r_s1_coef[7:4], r_s1_d);
   assign w_acc = r_s1_coef[8] ? (w_t0 - w_t1) : (w_t0 + w_t1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2_vld <= 1'b0;
         r_s2_sof <= 1'b0;
         r_s2_acc <= '0;
      end else if (w_en) begin
         r_s2_vld <= r_s1_vld;
         r_s2_sof <= r_s1_sof;
         r_s2_acc <= w_acc;
      end
   end

   // Round half up, then re-centre on MID and saturate to the pixel range
   assign w_sum = $signed({{(SW-DW){r_s2_acc[DW-1]}}, r_s2_acc})
                + $signed(SW'(2 ** (FRAC - 1)));
   assign w_rnd = w_sum >>> FRAC;
   assign w_val = w_rnd + $signed(SW'(MID));

   always_comb begin
      w_pix = w_val[PIX_W-1:0];
      if (w_val[SW-1])
         w_pix = '0;
      else if (w_val > $signed(SW'(2 ** PIX_W - 1)))
         w_pix = '1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_vld   <= 1'b0;
         r_out_sof   <= 1'b0;
         r_out_pixel <= '0;
      end else if (w_en) begin
         r_out_vld   <= r_s2_vld;
         r_out_sof   <= r_s2_sof;
         r_out_pixel <= w_pix;
      end
   end

   assign in_ready  = w_en;
   assign out_valid = r_out_vld;
   assign out_sof   = r_out_sof;
   assign out_pixel = r_out_pixel;
   assign param_err = r_param_err;

endmodule

// File: tb/tb_contrast_apply.sv
// Directed + randomized bench for contrast_apply with a queue scoreboard and
// an independent arithmetic reference model in eighths.
module tb_contrast_apply;

   localparam logic [8:0] X1 = 9'b000000100;

   logic       clk = 1'b0;
   logic       reset;
   logic       cp_update;
   logic [8:0] cp_param;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_pixel;
   logic       in_sof;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_pixel;
   logic       out_sof;
   logic       param_err;

   contrast_apply dut (
      .clk       (clk),
      .reset     (reset),
      .cp_update (cp_update),
      .cp_param  (cp_param),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pixel  (in_pixel),
      .in_sof    (in_sof),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pixel (out_pixel),
      .out_sof   (out_sof),
      .param_err (param_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] px;
      logic       sof;
   } sb_t;

   sb_t        sbq[$];
   int         checks = 0;
   int         errors = 0;
   bit         rnd_ready = 1'b0;
   logic [8:0] m_pend = X1;
   logic [8:0] m_act  = X1;
   logic       m_err  = 1'b0;

   function automatic int term8(input logic [3:0] c);
      case (c)
         4'b0100: term8 = 8;
         4'b0101: term8 = 4;
         4'b0110: term8 = 2;
         4'b0111: term8 = 1;
         4'b1001: term8 = 16;
         4'b1010: term8 = 32;
         default: term8 = 0;
      endcase
   endfunction

   function automatic bit legal(input logic [8:0] p);
      logic [3:0] c0, c1;
      c0 = p[3:0];
      c1 = p[7:4];
      legal = (c0 inside {4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA}) &&
              (c1 inside {4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA});
   endfunction

   function automatic logic [7:0] model(input logic [7:0] px, input logic [8:0] c);
      int coef8, num, q, v;
      coef8 = c[8] ? term8(c[3:0]) - term8(c[7:4]) : term8(c[3:0]) + term8(c[7:4]);
      num = (int'(px) - 128) * coef8 + 4;
      q = num / 8;
      if (num < 0 && (num % 8) != 0) q = q - 1;
      v = 128 + q;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      model = 8'(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, note accept/transfer, update the model, score output
   task automatic cycle(input logic vld, input logic [7:0] px, input logic sof,
                        input logic upd, input logic [8:0] prm, input int exp,
                        output logic accepted);
      logic       fire;
      logic [7:0] opx;
      logic       osof;
      logic [8:0] san;
      logic [8:0] use_c;
      sb_t        e;
      sb_t        got;
      @(negedge clk);
      in_valid  = vld;
      in_pixel  = px;
      in_sof    = sof;
      cp_update = upd;
      cp_param  = prm;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      accepted = vld && in_ready;
      fire     = out_valid && out_ready;
      opx      = out_pixel;
      osof     = out_sof;
      if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 0);
      san = legal(prm) ? prm : X1;
      if (accepted) begin
         use_c  = sof ? (upd ? san : m_pend) : m_act;
         e.px   = (exp >= 0) ? 8'(exp) : model(px, use_c);
         e.sof  = sof;
         sbq.push_back(e);
         if (sof) m_act = use_c;
      end
      if (upd) begin
         m_pend = san;
         m_err  = !legal(prm);
      end
      @(posedge clk);
      #1;
      cp_update = 1'b0;
      if (fire) begin
         if (sbq.size() == 0) begin
            chk("unexpected_output", 32'(opx), 32'hFFFF);
         end else begin
            got = sbq.pop_front();
            chk("out_pixel", 32'(opx), 32'(got.px));
            chk("out_sof", 32'(osof), 32'(got.sof));
         end
      end
   endtask

   task automatic send(input logic [7:0] px, input logic sof, input logic upd,
                       input logic [8:0] prm, input int exp);
      logic a;
      a = 1'b0;
      for (int k = 0; k < 200 && !a; k++)
         cycle(1'b1, px, sof, upd && (k == 0), prm, exp, a);
      if (!a) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input logic upd, input logic [8:0] prm);
      logic a;
      cycle(1'b0, 8'd0, 1'b0, upd, prm, -1, a);
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && (sbq.size() != 0 || out_valid); k++)
         idle(1'b0, X1);
      chk("drain_empty", 32'(sbq.size()), 0);
   endtask

   logic [8:0] plist[6] = '{9'b000000100, 9'b101110100, 9'b010101001,
                            9'b000000111, 9'b000001001, 9'b001010110};

   initial begin
      reset     = 1'b1;
      cp_update = 1'b0;
      cp_param  = 9'd0;
      in_valid  = 1'b0;
      in_pixel  = 8'd0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_pixel", 32'(out_pixel), 0);
      chk("rst_out_sof", 32'(out_sof), 0);
      chk("rst_param_err", 32'(param_err), 0);
      @(negedge clk);
      reset = 1'b0;

      // default coefficient x1 and 3-cycle latency
      send(8'd0, 1'b1, 1'b0, X1, 0);
      chk("lat_edge1", 32'(out_valid), 0);
      idle(1'b0, X1);
      chk("lat_edge2", 32'(out_valid), 0);
      idle(1'b0, X1);
      chk("lat_edge3_valid", 32'(out_valid), 1);
      chk("lat_edge3_pixel", 32'(out_pixel), 0);
      chk("lat_edge3_sof", 32'(out_sof), 1);
      send(8'd77, 1'b0, 1'b0, X1, 77);
      send(8'd255, 1'b0, 1'b0, X1, 255);
      drain();

      // coef 0.875 applied on the SOF that carries the update
      send(8'd200, 1'b1, 1'b1, 9'b101110100, 191);
      send(8'd56, 1'b0, 1'b0, X1, 65);
      // coef 6 clamps; coef 0 pins to MID
      send(8'd255, 1'b1, 1'b1, 9'b010101001, 255);
      send(8'd0, 1'b0, 1'b0, X1, 0);
      send(8'd77, 1'b1, 1'b1, 9'b000000000, 128);
      send(8'd250, 1'b0, 1'b0, X1, 128);
      // coef 0.125 rounding
      send(8'd131, 1'b1, 1'b1, 9'b000000111, 128);
      send(8'd132, 1'b0, 1'b0, X1, 129);
      send(8'd124, 1'b0, 1'b0, X1, 128);
      send(8'd123, 1'b0, 1'b0, X1, 127);
      drain();

      // mid-frame update waits for the next SOF
      send(8'd100, 1'b1, 1'b1, X1, 100);
      send(8'd200, 1'b0, 1'b1, 9'b000001001, 200);
      send(8'd150, 1'b0, 1'b0, X1, 150);
      send(8'd150, 1'b1, 1'b0, X1, 172);
      send(8'd100, 1'b0, 1'b0, X1, 72);
      // illegal code sets param_err and falls back to x1
      send(8'd110, 1'b0, 1'b1, 9'b000001111, 92);
      chk("perr_set", 32'(param_err), 1);
      send(8'd60, 1'b1, 1'b0, X1, 60);
      idle(1'b1, 9'b000001001);
      chk("perr_clear", 32'(param_err), 0);
      send(8'd130, 1'b1, 1'b0, X1, 132);
      drain();

      // random backpressure, bubbles and parameter churn, reset mid-stream
      rnd_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic       upd;
         logic [8:0] prm;
         logic       sof;
         if (i == 600) begin
            reset = 1'b1;
            #1;
            chk("reset_midstream_out_valid", 32'(out_valid), 0);
            sbq.delete();
            m_pend = X1;
            m_act  = X1;
            m_err  = 1'b0;
            @(negedge clk);
            reset = 1'b0;
         end
         sof = (i % 50 == 0);
         upd = ($urandom_range(0, 9) == 0);
         prm = ($urandom_range(0, 5) == 0) ? 9'($urandom_range(0, 511))
                                           : plist[$urandom_range(0, 5)];
         if ($urandom_range(0, 3) == 0) idle(1'b0, X1);
         send(8'($urandom_range(0, 255)), sof, upd, prm, -1);
         if (upd) chk("rand_param_err", 32'(param_err), 32'(m_err));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
